mux_barrido: RTL

- Parametrised, registered N-channel multiplexer with two modes: manual select and automatic scanning of channels.
- Generalises the 16:1 bit-select mux to ANCHO-bit channels and a programmable channel count.
- Adds a masked round-robin scanner with a per-channel dwell time, and valid/end-of-sweep strobes.
- Sits between banks of sampled signals and the display/serial stages that consume one channel at a time.

---
 rtl/mux_barrido.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mux_barrido.sv
// Registered N-channel multiplexer with manual select and a masked round-robin
// scanner that dwells PERMANENCIA enabled cycles per channel.
module mux_barrido #(
    parameter int N_CANALES   = 16,
    parameter int ANCHO       = 1,
    parameter int ANCHO_SEL   = 4,
    parameter int PERMANENCIA = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         modo,
    input  logic [ANCHO_SEL-1:0]         Seleccion,
    input  logic [N_CANALES*ANCHO-1:0]   Dn,
    input  logic [N_CANALES-1:0]         mascara,
    output logic [ANCHO-1:0]             Y,
    output logic [ANCHO_SEL-1:0]         canal,
    output logic                         valido,
    output logic                         fin_barrido
);
    localparam int CW = $clog2(PERMANENCIA) + 1;
    localparam logic [CW-1:0] ULTIMO = CW'(PERMANENCIA - 1);

    typedef enum logic [0:0] {MANUAL = 1'b0, BARRIDO = 1'b1} estado_t;

    estado_t                estado_r, estado_s;
    logic [CW-1:0]          cnt_r, cnt_s;
    logic [ANCHO_SEL-1:0]   canal_r, canal_s;
    logic [ANCHO-1:0]       y_r, y_s;
    logic                   valido_r, valido_s;
    logic                   fin_r, fin_s;
    logic [ANCHO_SEL-1:0]   primero_s, siguiente_s;
    logic                   hay_s, hay_sig_s;

    // Out-of-range indices yield zero instead of an illegal slice.
    function automatic logic [ANCHO-1:0] dato_canal(
        input logic [N_CANALES*ANCHO-1:0] dn,
        input logic [ANCHO_SEL-1:0]       idx
    );
        logic [ANCHO-1:0] d;
        d = '0;
        for (int k = 0; k < N_CANALES; k++) begin
            d = (int'(idx) == k) ? dn[k*ANCHO +: ANCHO] : d;
        end
        return d;
    endfunction

    // Priority search: lowest enabled channel and lowest enabled channel above canal_r.
    always_comb begin
        primero_s   = '0;
        siguiente_s = '0;
        hay_s       = 1'b0;
        hay_sig_s   = 1'b0;
        for (int k = N_CANALES - 1; k >= 0; k--) begin
            primero_s   = mascara[k] ? ANCHO_SEL'(k) : primero_s;
            hay_s       = hay_s | mascara[k];
            siguiente_s = (mascara[k] && (k > int'(canal_r))) ? ANCHO_SEL'(k) : siguiente_s;
            hay_sig_s   = hay_sig_s | (mascara[k] && (k > int'(canal_r)));
        end
    end

    // Next-state and next-output decision for one enabled edge.
    always_comb begin
        estado_s = estado_r;
        cnt_s    = cnt_r;
        canal_s  = canal_r;
        valido_s = valido_r;
        fin_s    = 1'b0;
        if (!modo) begin
            estado_s = MANUAL;
            cnt_s    = '0;
            canal_s  = Seleccion;
            valido_s = (int'(Seleccion) < N_CANALES);
        end else begin
            estado_s = BARRIDO;
            if (!hay_s) begin
                valido_s = 1'b0;
            end else if ((estado_r == MANUAL) || !valido_r) begin
                // Fresh start: entering scan or recovering from an empty mask.
                canal_s  = primero_s;
                cnt_s    = '0;
                valido_s = 1'b1;
            end else if (cnt_r != ULTIMO) begin
                cnt_s = cnt_r + CW'(1);
            end else begin
                cnt_s   = '0;
                canal_s = hay_sig_s ? siguiente_s : primero_s;
                fin_s   = ~hay_sig_s;
            end
        end
        y_s = valido_s ? dato_canal(Dn, canal_s) : '0;
    end

    // State and output registers; a disabled edge only clears the sweep strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= MANUAL;
            cnt_r    <= '0;
            canal_r  <= '0;
            y_r      <= '0;
            valido_r <= 1'b0;
            fin_r    <= 1'b0;
        end else if (en) begin
            estado_r <= estado_s;
            cnt_r    <= cnt_s;
            canal_r  <= canal_s;
            y_r      <= y_s;
            valido_r <= valido_s;
            fin_r    <= fin_s;
        end else begin
            fin_r    <= 1'b0;
        end
    end

    assign Y           = y_r;
    assign canal       = canal_r;
    assign valido      = valido_r;
    assign fin_barrido = fin_r;

endmodule
